ram_ctrl: RTL and testbench

Memory access sequencer that sits directly upstream of the processor's 8-word × 3-bit data RAM. It turns single-cycle read/write strobes from the control unit into correctly timed RAM write-enable, address and data signals. It captures the RAM's registered read output and returns it with a `done` pulse. It also provides a scan mode that streams every RAM word out on consecutive cycles for the display path.

---
 rtl/ram_ctrl.sv | 125 ++++++++++++
 tb/tb_ram_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/ram_ctrl.sv
// Sequences single-cycle read/write strobes and full scans onto a registered-output RAM.
// Write done at accept+1, read done at accept+2, scan words from start+2; strobes while busy are dropped.
module ram_ctrl #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 3,
  parameter int DEPTH  = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req,
  input  logic              rw,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  input  logic              scan_start,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              scan_valid,
  output logic [ADDR_W-1:0] scan_addr,
  output logic              scan_last,
  output logic              ram_enable,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_q
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WR      = 3'd1;
  localparam logic [2:0] S_RD_ADDR = 3'd2;
  localparam logic [2:0] S_RD_CAP  = 3'd3;
  localparam logic [2:0] S_SCAN    = 3'd4;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  logic [2:0]        state;
  // Second scan pipeline stage: the address whose word is on ram_q this cycle.
  logic              cap_vld;
  logic [ADDR_W-1:0] cap_addr;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      rdata      <= '0;
      scan_valid <= 1'b0;
      scan_addr  <= '0;
      scan_last  <= 1'b0;
      ram_enable <= 1'b0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      cap_vld    <= 1'b0;
      cap_addr   <= '0;
    end else begin
      done       <= 1'b0;
      scan_valid <= 1'b0;
      scan_last  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req) begin
            ram_addr   <= req_addr;
            ram_enable <= 1'b1;
            busy       <= 1'b1;
            if (rw) begin
              ram_we    <= 1'b1;
              ram_wdata <= req_data;
              state     <= S_WR;
            end else begin
              ram_we <= 1'b0;
              state  <= S_RD_ADDR;
            end
          end else if (scan_start) begin
            ram_addr   <= '0;
            ram_enable <= 1'b1;
            ram_we     <= 1'b0;
            busy       <= 1'b1;
            cap_vld    <= 1'b0;
            state      <= S_SCAN;
          end
        end
        S_WR: begin
          ram_we     <= 1'b0;
          ram_enable <= 1'b0;
          busy       <= 1'b0;
          done       <= 1'b1;
          state      <= S_IDLE;
        end
        S_RD_ADDR: begin
          ram_enable <= 1'b0;
          state      <= S_RD_CAP;
        end
        S_RD_CAP: begin
          rdata <= ram_q;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        S_SCAN: begin
          cap_vld  <= ram_enable;
          cap_addr <= ram_addr;
          // Stop issuing at the last address; stay in SCAN until it drains.
          if (ram_enable) begin
            if (ram_addr == LAST) ram_enable <= 1'b0;
            else                  ram_addr   <= ram_addr + 1'b1;
          end
          if (cap_vld) begin
            rdata      <= ram_q;
            scan_valid <= 1'b1;
            scan_addr  <= cap_addr;
            if (cap_addr == LAST) begin
              scan_last <= 1'b1;
              done      <= 1'b1;
              busy      <= 1'b0;
              state     <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_ctrl.sv
// Bench for ram_ctrl: behavioural RAM plus a reference memory image and fixed-latency expectations.
module tb_ram_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       req = 1'b0;
  logic       rw = 1'b0;
  logic [2:0] req_addr = '0;
  logic [2:0] req_data = '0;
  logic       scan_start = 1'b0;
  logic       busy, done, scan_valid, scan_last, ram_enable, ram_we;
  logic [2:0] rdata, scan_addr, ram_addr, ram_wdata;
  logic [2:0] ram_q = '0;

  logic [2:0] ram_mem [0:7] = '{3'd5, 3'd1, 3'd2, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
  logic [2:0] ref_mem [0:7] = '{3'd5, 3'd1, 3'd2, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};

  int tests  = 0;
  int failed = 0;

  always #5 clock = ~clock;

  ram_ctrl #(.ADDR_W(3), .DATA_W(3), .DEPTH(8)) dut (
    .clock(clock), .reset(reset), .req(req), .rw(rw), .req_addr(req_addr),
    .req_data(req_data), .scan_start(scan_start), .busy(busy), .done(done),
    .rdata(rdata), .scan_valid(scan_valid), .scan_addr(scan_addr),
    .scan_last(scan_last), .ram_enable(ram_enable), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_q(ram_q)
  );

  // Synchronous RAM with registered read output.
  always @(posedge clock) begin
    if (ram_enable) begin
      if (ram_we) ram_mem[ram_addr] <= ram_wdata;
      else        ram_q <= ram_mem[ram_addr];
    end
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [2:0] a, input logic [2:0] d);
    req = 1'b1; rw = 1'b1; req_addr = a; req_data = d;
    tick;
    req = 1'b0;
    chk("wr_we", ram_we, 1);
    chk("wr_en", ram_enable, 1);
    chk("wr_busy", busy, 1);
    chk("wr_addr", ram_addr, a);
    chk("wr_wdata", ram_wdata, d);
    chk("wr_done_early", done, 0);
    tick;
    chk("wr_we_off", ram_we, 0);
    chk("wr_done", done, 1);
    chk("wr_busy_off", busy, 0);
    ref_mem[a] = d;
  endtask

  task automatic do_read(input logic [2:0] a);
    req = 1'b1; rw = 1'b0; req_addr = a;
    tick;
    req = 1'b0;
    chk("rd_busy", busy, 1);
    chk("rd_we", ram_we, 0);
    chk("rd_addr", ram_addr, a);
    chk("rd_done_early", done, 0);
    tick;
    chk("rd_done_mid", done, 0);
    tick;
    chk("rd_done", done, 1);
    chk("rd_data", rdata, ref_mem[a]);
    chk("rd_busy_off", busy, 0);
  endtask

  task automatic do_scan;
    scan_start = 1'b1;
    tick;
    scan_start = 1'b0;
    chk("scan_busy", busy, 1);
    chk("scan_addr0", ram_addr, 0);
    tick;
    chk("scan_valid_early", scan_valid, 0);
    for (int i = 0; i < 8; i++) begin
      tick;
      chk("scan_valid", scan_valid, 1);
      chk("scan_addr", scan_addr, i);
      chk("scan_data", rdata, ref_mem[i]);
      chk("scan_last", scan_last, (i == 7) ? 1 : 0);
      chk("scan_done", done, (i == 7) ? 1 : 0);
      chk("scan_busy_run", busy, (i == 7) ? 0 : 1);
    end
    tick;
    chk("scan_valid_after", scan_valid, 0);
    chk("scan_done_after", done, 0);
  endtask

  initial begin
    logic [2:0] a;
    logic [2:0] d;

    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_scan_valid", scan_valid, 0);
    chk("rst_scan_addr", scan_addr, 0);
    chk("rst_scan_last", scan_last, 0);
    chk("rst_ram_en", ram_enable, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_wdata", ram_wdata, 0);
    reset = 1'b0;
    tick;

    do_read(3'd0);
    chk("preload_0", rdata, 5);
    do_read(3'd2);
    chk("preload_2", rdata, 2);

    do_write(3'd4, 3'd6);
    do_read(3'd4);
    chk("wr_rd_4", rdata, 6);

    for (int i = 3; i < 8; i++) do_write(3'(i), 3'(i));
    do_scan;

    // A write strobe during RD_ADDR must vanish.
    req = 1'b1; rw = 1'b0; req_addr = 3'd0;
    tick;
    req = 1'b1; rw = 1'b1; req_addr = 3'd6; req_data = 3'd1;
    chk("drop_addr_a", ram_addr, 0);
    tick;
    req = 1'b0;
    chk("drop_addr_b", ram_addr, 0);
    chk("drop_we", ram_we, 0);
    chk("drop_done_mid", done, 0);
    tick;
    chk("drop_done", done, 1);
    chk("drop_rdata", rdata, ref_mem[0]);
    tick;
    chk("drop_no_extra_done", done, 0);
    chk("drop_idle", busy, 0);
    chk("drop_no_we", ram_we, 0);

    // Simultaneous req and scan_start: only the access runs.
    scan_start = 1'b1;
    do_read(3'd2);
    scan_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("collide_no_scan", scan_valid, 0);
      chk("collide_idle", busy, 0);
    end

    // Back-to-back: read strobed in the write's done cycle.
    do_write(3'd1, 3'd3);
    do_read(3'd1);
    chk("b2b_rdata", rdata, 3);

    // Reset during the WR cycle.
    req = 1'b1; rw = 1'b1; req_addr = 3'd5; req_data = 3'd7;
    tick;
    req = 1'b0;
    chk("mid_we_before", ram_we, 1);
    #2 reset = 1'b1;
    #1;
    chk("mid_we", ram_we, 0);
    chk("mid_en", ram_enable, 0);
    chk("mid_busy", busy, 0);
    chk("mid_addr", ram_addr, 0);
    chk("mid_rdata", rdata, 0);
    chk("mid_done", done, 0);
    tick;
    chk("mid_done_edge", done, 0);
    reset = 1'b0;
    tick;
    chk("mid_done_after", done, 0);
    chk("mid_mem5", ram_mem[5], ref_mem[5]);
    do_read(3'd5);

    // Randomized traffic against the reference image.
    for (int i = 0; i < 40; i++) begin
      a = 3'($urandom_range(0, 7));
      d = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 2))
        0: do_write(a, d);
        1: do_read(a);
        default: begin
          tick;
          chk("gap_done", done, 0);
        end
      endcase
    end
    do_scan;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
